// File: rtl/v_matvec_mult.sv
// v_matvec_mult: chunked fixed-point y = W*x feeding the leaky-ReLU stage.
// Buffers x, streams W rows from a 1-cycle ROM, pushes saturated y chunks.
module v_matvec_mult #(
  parameter int InVecLength  = 8,
  parameter int OutVecLength = 8,
  parameter int NBits        = 16,
  parameter int FracBits     = 8,
  parameter int WorkingRegs  = 2,
  localparam int AddrW =
    $clog2(OutVecLength * InVecLength / WorkingRegs)
) (
  input  logic                         clk_in,
  input  logic                         rst_in,
  input  logic                         in_data_ready,
  input  logic [WorkingRegs*NBits-1:0] in_data,
  output logic                         req_chunk_in,
  output logic [AddrW-1:0]             weight_addr,
  input  logic [WorkingRegs*NBits-1:0] weight_data,
  input  logic                         out_ready,
  output logic [WorkingRegs*NBits-1:0] write_out_data,
  output logic                         req_chunk_out,
  output logic                         out_vector_valid,
  output logic                         busy
);

  localparam int C    = InVecLength / WorkingRegs;
  localparam int CW   = $clog2(C + 1);
  localparam int RW   = $clog2(OutVecLength + 1);
  localparam int XW   = (InVecLength > 1) ? $clog2(InVecLength) : 1;
  localparam int LW   = (WorkingRegs > 1) ? $clog2(WorkingRegs) : 1;
  localparam int AccW = 2 * NBits + $clog2(InVecLength) + 1;

  localparam logic signed [AccW-1:0] SatMax =
    {{(AccW - NBits + 1){1'b0}}, {(NBits - 1){1'b1}}};
  localparam logic signed [AccW-1:0] SatMin =
    {{(AccW - NBits + 1){1'b1}}, {(NBits - 1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    COMPUTE,
    WRITE
  } state_e;

  state_e                   state_q, state_d;
  logic [CW-1:0]            c_q, c_d;
  logic [CW-1:0]            k_q, k_d;
  logic [RW-1:0]            r_q, r_d;
  logic signed [AccW-1:0]   acc_q, acc_d;
  logic signed [NBits-1:0]  x_q [InVecLength];
  logic signed [NBits-1:0]  x_d [InVecLength];
  logic signed [NBits-1:0]  oc_q [WorkingRegs];
  logic signed [NBits-1:0]  oc_d [WorkingRegs];

  logic [CW-1:0]            kk;
  logic [CW-1:0]            ka;
  logic [XW-1:0]            xi;
  logic [LW-1:0]            lane;
  logic signed [2*NBits-1:0] prod [WorkingRegs];
  logic signed [AccW-1:0]   dot;
  logic signed [AccW-1:0]   sum;
  logic signed [AccW-1:0]   shifted;
  logic signed [NBits-1:0]  res;

  // Dot product of the ROM word with the x chunk addressed last cycle
  always_comb begin
    kk  = (k_q == '0) ? '0 : k_q - CW'(1);
    ka  = (k_q < CW'(C)) ? k_q : CW'(C - 1);
    xi  = '0;
    dot = '0;
    for (int i = 0; i < WorkingRegs; i++) begin
      xi      = XW'(int'(kk) * WorkingRegs + i);
      prod[i] = $signed(weight_data[i*NBits +: NBits]) * x_q[xi];
      dot     = dot + AccW'(prod[i]);
    end
    sum     = acc_q + dot;
    shifted = sum >>> FracBits;
    if (shifted > SatMax) begin
      res = SatMax[NBits-1:0];
    end else if (shifted < SatMin) begin
      res = SatMin[NBits-1:0];
    end else begin
      res = shifted[NBits-1:0];
    end
    lane        = LW'(int'(r_q) % WorkingRegs);
    weight_addr = AddrW'(int'(r_q) * C + int'(ka));
  end

  // Handshake outputs and the packed output chunk
  always_comb begin
    req_chunk_in     = (state_q == LOAD) && in_data_ready;
    req_chunk_out    = (state_q == WRITE) && out_ready;
    out_vector_valid = req_chunk_out && (r_q == RW'(OutVecLength));
    busy             = (state_q != IDLE);
    write_out_data   = '0;
    for (int i = 0; i < WorkingRegs; i++) begin
      write_out_data[i*NBits +: NBits] = oc_q[i];
    end
  end

  // Next-state: load x, run rows one at a time, flush full out chunks
  always_comb begin
    state_d = state_q;
    c_d     = c_q;
    k_d     = k_q;
    r_d     = r_q;
    acc_d   = acc_q;
    x_d     = x_q;
    oc_d    = oc_q;
    case (state_q)
      IDLE: begin
        if (in_data_ready) begin
          state_d = LOAD;
          c_d     = '0;
        end
      end
      LOAD: begin
        if (in_data_ready) begin
          for (int i = 0; i < WorkingRegs; i++) begin
            x_d[XW'(int'(c_q) * WorkingRegs + i)] =
              in_data[i*NBits +: NBits];
          end
          c_d = c_q + CW'(1);
          if (c_q == CW'(C - 1)) begin
            state_d = COMPUTE;
            r_d     = '0;
            k_d     = '0;
          end
        end
      end
      COMPUTE: begin
        if (k_q == '0) begin
          acc_d = '0;
          k_d   = CW'(1);
        end else begin
          acc_d = sum;
          if (k_q == CW'(C)) begin
            oc_d[lane] = res;
            r_d        = r_q + RW'(1);
            k_d        = '0;
            if (lane == LW'(WorkingRegs - 1)) begin
              state_d = WRITE;
            end
          end else begin
            k_d = k_q + CW'(1);
          end
        end
      end
      WRITE: begin
        if (out_ready) begin
          state_d = (r_q == RW'(OutVecLength)) ? IDLE : COMPUTE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_q <= IDLE;
      c_q     <= '0;
      k_q     <= '0;
      r_q     <= '0;
      acc_q   <= '0;
      for (int i = 0; i < InVecLength; i++) begin
        x_q[i] <= '0;
      end
      for (int i = 0; i < WorkingRegs; i++) begin
        oc_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      c_q     <= c_d;
      k_q     <= k_d;
      r_q     <= r_d;
      acc_q   <= acc_d;
      x_q     <= x_d;
      oc_q    <= oc_d;
    end
  end

endmodule

// File: tb/tb_v_matvec_mult.sv
// tb_v_matvec_mult: scoreboard bench for the 4x4 chunked mat-vec stage.
// Input FIFO and weight ROM are modelled; a monitor checks each push.
module tb_v_matvec_mult;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_data_ready = 1'b0;
  logic [31:0] in_data = '0;
  logic        req_chunk_in;
  logic [2:0]  weight_addr;
  logic [31:0] weight_data = '0;
  logic        out_ready = 1'b1;
  logic [31:0] write_out_data;
  logic        req_chunk_out;
  logic        out_vector_valid;
  logic        busy;

  typedef struct packed {
    logic [31:0] d;
    logic        last;
  } exp_t;

  logic [15:0] W [4][4];
  logic [31:0] fifo [$];
  exp_t        sb [$];
  int          pop_cyc [$];
  int          ovv_cyc [$];
  bit          pop_pend = 1'b0;
  int          pops = 0;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;

  v_matvec_mult #(
    .InVecLength (4),
    .OutVecLength(4),
    .NBits       (16),
    .FracBits    (8),
    .WorkingRegs (2)
  ) dut (
    .clk_in          (clk),
    .rst_in          (rst_n),
    .in_data_ready   (in_data_ready),
    .in_data         (in_data),
    .req_chunk_in    (req_chunk_in),
    .weight_addr     (weight_addr),
    .weight_data     (weight_data),
    .out_ready       (out_ready),
    .write_out_data  (write_out_data),
    .req_chunk_out   (req_chunk_out),
    .out_vector_valid(out_vector_valid),
    .busy            (busy)
  );

  always #5 clk = ~clk;

  // Cycle counter
  always @(posedge clk) cyc <= cyc + 1;

  // Weight ROM, one cycle read latency
  always @(posedge clk) begin
    weight_data <= {W[weight_addr[2:1]][{weight_addr[0], 1'b1}],
                    W[weight_addr[2:1]][{weight_addr[0], 1'b0}]};
  end

  // Input FIFO: retire last edge's pop, present head, sample pop request
  always @(negedge clk) begin
    if (pop_pend) begin
      fifo.delete(0);
      pops = pops + 1;
    end
    in_data_ready = (fifo.size() > 0);
    in_data = (fifo.size() > 0) ? fifo[0] : 32'h0;
    #1;
    pop_pend = req_chunk_in;
    if (pop_pend) pop_cyc.push_back(cyc);
  end

  task automatic check(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      errors = errors + 1;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  // Output monitor: every push is compared with the scoreboard head
  always @(negedge clk) begin
    exp_t e;
    #1;
    if (req_chunk_out) begin
      if (out_vector_valid) ovv_cyc.push_back(cyc);
      if (sb.size() == 0) begin
        checks = checks + 1;
        errors = errors + 1;
        $display("FAIL unexpected_push got=%h exp=none",
                 write_out_data);
      end else begin
        e = sb.pop_front();
        check("push_data", write_out_data, e.d);
        check("push_last", 32'(out_vector_valid), 32'(e.last));
      end
    end
  end

  task automatic w_ident();
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        W[r][c] = (r == c) ? 16'h0100 : 16'h0000;
  endtask

  task automatic w_row0();
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        W[r][c] = (r == 0) ? 16'h0100 : 16'h0000;
  endtask

  task automatic w_fill(input logic [15:0] v);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        W[r][c] = v;
  endtask

  task automatic expect_y(input logic [15:0] y0, y1, y2, y3);
    sb.push_back('{d: {y1, y0}, last: 1'b0});
    sb.push_back('{d: {y3, y2}, last: 1'b1});
  endtask

  task automatic issue(input logic [15:0] x0, x1, x2, x3);
    fifo.push_back({x1, x0});
    fifo.push_back({x3, x2});
  endtask

  task automatic wait_idle(input string nm, input int maxc);
    int n = 0;
    while ((sb.size() != 0 || busy) && n < maxc) begin
      @(posedge clk);
      n++;
    end
    if (n >= maxc) begin
      checks = checks + 1;
      errors = errors + 1;
      $display("FAIL %s timeout got=%0d exp=<%0d cycles", nm, n, maxc);
    end
    repeat (2) @(posedge clk);
    #2;
  endtask

  task automatic wait_pops(input string nm, input int target);
    int n = 0;
    while (pops < target && n < 100) begin
      @(posedge clk);
      n++;
    end
    if (n >= 100) begin
      checks = checks + 1;
      errors = errors + 1;
      $display("FAIL %s pop_timeout got=%0d exp=%0d", nm, pops, target);
    end
  endtask

  task automatic check_reset_outs(input string nm);
    check({nm, "_busy"}, 32'(busy), 32'd0);
    check({nm, "_req_in"}, 32'(req_chunk_in), 32'd0);
    check({nm, "_req_out"}, 32'(req_chunk_out), 32'd0);
    check({nm, "_ovv"}, 32'(out_vector_valid), 32'd0);
    check({nm, "_addr"}, 32'(weight_addr), 32'd0);
    check({nm, "_wdata"}, write_out_data, 32'd0);
  endtask

  initial begin
    int p0;
    int lat;
    w_ident();
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    check_reset_outs("reset");
    @(posedge clk);
    #2;
    rst_n = 1'b1;

    // Identity and load-to-last-push latency
    pop_cyc.delete();
    ovv_cyc.delete();
    p0 = pops;
    expect_y(16'h0100, 16'h0200, 16'hFF00, 16'h0000);
    issue(16'h0100, 16'h0200, 16'hFF00, 16'h0000);
    wait_idle("t1", 200);
    lat = (pop_cyc.size() > 0 && ovv_cyc.size() > 0) ?
          ovv_cyc[0] - pop_cyc[0] : -1;
    check("t1_latency", 32'(lat), 32'd15);
    check("t1_pops", 32'(pops - p0), 32'd2);

    // Mixed row: 256*(1+1+1-0.5) = 640
    w_row0();
    expect_y(16'h0280, 16'h0000, 16'h0000, 16'h0000);
    issue(16'h0100, 16'h0100, 16'h0100, 16'hFF80);
    wait_idle("t2", 200);

    // Positive and negative saturation
    w_fill(16'h7FFF);
    expect_y(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF);
    issue(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF);
    wait_idle("t3a", 200);
    w_fill(16'h8000);
    expect_y(16'h8000, 16'h8000, 16'h8000, 16'h8000);
    issue(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF);
    wait_idle("t3b", 200);

    // Starved input between chunks
    w_ident();
    p0 = pops;
    expect_y(16'h0100, 16'h0200, 16'hFF00, 16'h0000);
    fifo.push_back({16'h0200, 16'h0100});
    wait_pops("t4a", p0 + 1);
    repeat (3) @(posedge clk);
    #2;
    fifo.push_back({16'h0000, 16'hFF00});
    wait_idle("t4a", 200);
    check("t4a_pops", 32'(pops - p0), 32'd2);

    // Output backpressure holds WRITE with frozen data and address
    out_ready = 1'b0;
    expect_y(16'h0100, 16'h0200, 16'hFF00, 16'h0000);
    issue(16'h0100, 16'h0200, 16'hFF00, 16'h0000);
    repeat (14) @(posedge clk);
    @(negedge clk);
    #1;
    check("t4b_busy", 32'(busy), 32'd1);
    check("t4b_noreq", 32'(req_chunk_out), 32'd0);
    check("t4b_data0", write_out_data, {16'h0200, 16'h0100});
    check("t4b_addr0", 32'(weight_addr), 32'd4);
    repeat (5) @(posedge clk);
    @(negedge clk);
    #1;
    check("t4b_data1", write_out_data, {16'h0200, 16'h0100});
    check("t4b_addr1", 32'(weight_addr), 32'd4);
    @(posedge clk);
    #2;
    out_ready = 1'b1;
    wait_idle("t4b", 200);

    // Reset during row 1 of COMPUTE discards the vector
    p0 = pops;
    issue(16'h0100, 16'h0200, 16'hFF00, 16'h0000);
    wait_pops("t5", p0 + 2);
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    check_reset_outs("t5");
    w_row0();
    expect_y(16'h0280, 16'h0000, 16'h0000, 16'h0000);
    issue(16'h0100, 16'h0100, 16'h0100, 16'hFF80);
    wait_idle("t5b", 200);

    // Two vectors queued back to back
    w_ident();
    pop_cyc.delete();
    ovv_cyc.delete();
    expect_y(16'h0100, 16'h0200, 16'hFF00, 16'h0000);
    expect_y(16'h0000, 16'hFF00, 16'h0200, 16'h0100);
    issue(16'h0100, 16'h0200, 16'hFF00, 16'h0000);
    issue(16'h0000, 16'hFF00, 16'h0200, 16'h0100);
    wait_idle("t6", 400);
    check("t6_ovv_count", 32'(ovv_cyc.size()), 32'd2);
    check("t6_order",
          32'((pop_cyc.size() == 4 && ovv_cyc.size() > 0) &&
              (pop_cyc[2] > ovv_cyc[0])), 32'd1);
    check("t6_sb_empty", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
